// File: rtl/melody_sequencer.sv
// Sound-effect sequencer: plays a fixed ROM of {note, duration} steps per effect.
// Latency: outputs change on the edge that samples trigger/stop; all outputs registered.
// No backpressure: trigger restarts at any time, stop aborts at any time (stop wins).
module melody_sequencer #(
  parameter int TICK_CLKS = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigger,
  input  logic [1:0] sfx_sel,
  input  logic       stop,
  output logic [3:0] note,
  output logic       note_en,
  output logic       busy,
  output logic       done
);

  localparam int TW = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CLKS - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t          state;
  logic [1:0]      sfx;
  logic [1:0]      step_idx;
  logic [TW-1:0]   tick_cnt;
  logic [3:0]      dur_cnt;

  // Step ROM: {note code, duration in ticks}; code 0 is a rest.
  function automatic logic [7:0] step_rom(input logic [1:0] sel, input logic [1:0] idx);
    logic [7:0] s;
    case ({sel, idx})
      4'b00_00: s = 8'h83;  // DROP  G5 3
      4'b00_01: s = 8'h13;  // DROP  C6 3
      4'b01_00: s = 8'h14;  // WIN   C6 4
      4'b01_01: s = 8'h34;  // WIN   E6 4
      4'b01_10: s = 8'h54;  // WIN   G6 4
      4'b01_11: s = 8'h7C;  // WIN   C7 12
      4'b10_00: s = 8'h86;  // LOSE  G5 6
      4'b10_01: s = 8'h96;  // LOSE  F4 6
      4'b10_10: s = 8'hAF;  // LOSE  B3 15
      4'b11_00: s = 8'hA4;  // ERROR B3 4
      4'b11_01: s = 8'h02;  // ERROR rest 2
      4'b11_10: s = 8'hA4;  // ERROR B3 4
      default:  s = 8'h00;
    endcase
    return s;
  endfunction

  // Index of the final step of each effect.
  function automatic logic [1:0] last_idx(input logic [1:0] sel);
    logic [1:0] l;
    case (sel)
      2'd0:    l = 2'd1;
      2'd1:    l = 2'd3;
      default: l = 2'd2;
    endcase
    return l;
  endfunction

  logic [7:0] cur_step;
  logic [7:0] nxt_step;
  logic [7:0] trig_step;
  logic       tick_wrap;
  logic       play_end;
  logic       last_step;

  assign cur_step  = step_rom(sfx, step_idx);
  assign nxt_step  = step_rom(sfx, step_idx + 2'd1);
  assign trig_step = step_rom(sfx_sel, 2'd0);
  assign tick_wrap = (tick_cnt == TICK_LAST);
  assign play_end  = tick_wrap && (dur_cnt == cur_step[3:0] - 4'd1);
  assign last_step = (step_idx == last_idx(sfx));

  // Sequencer FSM with registered outputs; counters clear on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sfx      <= 2'd0;
      step_idx <= 2'd0;
      tick_cnt <= '0;
      dur_cnt  <= 4'd0;
      note     <= 4'd0;
      note_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        step_idx <= 2'd0;
        tick_cnt <= '0;
        dur_cnt  <= 4'd0;
        note     <= 4'd0;
        note_en  <= 1'b0;
        busy     <= 1'b0;
      end else if (trigger) begin
        // Restart from step 0 regardless of current state; no done for the old effect.
        state    <= PLAY;
        sfx      <= sfx_sel;
        step_idx <= 2'd0;
        tick_cnt <= '0;
        dur_cnt  <= 4'd0;
        note     <= trig_step[7:4];
        note_en  <= (trig_step[7:4] != 4'd0);
        busy     <= 1'b1;
      end else begin
        case (state)
          PLAY: begin
            if (play_end) begin
              tick_cnt <= '0;
              dur_cnt  <= 4'd0;
              note     <= 4'd0;
              note_en  <= 1'b0;
              if (last_step) begin
                state    <= IDLE;
                step_idx <= 2'd0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else begin
                state <= GAP;
              end
            end else if (tick_wrap) begin
              tick_cnt <= '0;
              dur_cnt  <= dur_cnt + 4'd1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          GAP: begin
            if (tick_wrap) begin
              state    <= PLAY;
              step_idx <= step_idx + 2'd1;
              tick_cnt <= '0;
              dur_cnt  <= 4'd0;
              note     <= nxt_step[7:4];
              note_en  <= (nxt_step[7:4] != 4'd0);
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            tick_cnt <= '0;
            dur_cnt  <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule
